// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator (640x480 @ 60 Hz by default).
//
// Ports:
//   vga_clk     - pixel clock, all state changes on the rising edge
//   reset_n     - asynchronous active-low reset
//   DrawX/DrawY - current horizontal/vertical count
//   blank       - 1 inside the visible area (display enable)
//   hs/vs       - raw syncs, aligned to DrawX/DrawY
//   hs_out/vs_out - syncs delayed by PIPE_DLY cycles, for the connector
//   line_start  - 1 while DrawX == 0
//   frame_start - 1 while DrawX == 0 and DrawY == 0
//   frame_count - frame index, steps on the edge that enters (0,0)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned PIPE_DLY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_out,
  output logic       vs_out,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_hc, r_vc;
  logic [9:0] w_hc_nxt, w_vc_nxt;
  logic       w_frame_wrap;
  logic       r_blank, r_hs, r_vs, r_line_start, r_frame_start;
  logic [7:0] r_frame_count;

  always_comb begin
    w_hc_nxt = r_hc + 10'd1;
    w_vc_nxt = r_vc;
    if (r_hc == H_LAST) begin
      w_hc_nxt = 10'd0;
      w_vc_nxt = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
    end
  end

  assign w_frame_wrap = (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);

  // Decoded outputs are registered from the next-state counters so they stay
  // cycle-aligned with DrawX/DrawY and cannot glitch.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc          <= H_LAST;
      r_vc          <= V_LAST;
      r_blank       <= 1'b0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'hFF;
    end else begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_blank       <= (w_hc_nxt < H_VIS) && (w_vc_nxt < V_VIS);
      r_hs          <= ((w_hc_nxt >= HS_BEG) && (w_hc_nxt < HS_END)) ? HS_POL : ~HS_POL;
      r_vs          <= ((w_vc_nxt >= VS_BEG) && (w_vc_nxt < VS_END)) ? VS_POL : ~VS_POL;
      r_line_start  <= (w_hc_nxt == 10'd0);
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Sync delay lines so connector syncs line up with registered colour.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign hs_out = r_hs;
    assign vs_out = r_vs;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] r_hs_dly, r_vs_dly;

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hs_dly <= {PIPE_DLY{~HS_POL}};
        r_vs_dly <= {PIPE_DLY{~VS_POL}};
      end else begin
        r_hs_dly[0] <= r_hs;
        r_vs_dly[0] <= r_vs;
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
          r_hs_dly[i] <= r_hs_dly[i-1];
          r_vs_dly[i] <= r_vs_dly[i-1];
        end
      end
    end

    assign hs_out = r_hs_dly[PIPE_DLY-1];
    assign vs_out = r_vs_dly[PIPE_DLY-1];
  end

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Four instances share clock and reset: default 640x480 timing with PIPE_DLY 0, 1, 2, and
// a tiny raster (8x6, active-high syncs, PIPE_DLY 4) so whole frames and the frame_count
// wrap fit in a short run. Expected outputs come from plain arithmetic on the number of
// clock edges since reset release.
module tb_vga_timing_gen;

  localparam int N = 4;

  localparam int unsigned HV  [N] = '{640, 640, 640, 4};
  localparam int unsigned HF  [N] = '{16, 16, 16, 1};
  localparam int unsigned HSY [N] = '{96, 96, 96, 2};
  localparam int unsigned HB  [N] = '{48, 48, 48, 1};
  localparam int unsigned VV  [N] = '{480, 480, 480, 3};
  localparam int unsigned VF  [N] = '{10, 10, 10, 1};
  localparam int unsigned VSY [N] = '{2, 2, 2, 1};
  localparam int unsigned VB  [N] = '{33, 33, 33, 1};
  localparam bit          HP  [N] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam bit          VP  [N] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam int unsigned PD  [N] = '{0, 1, 2, 4};

  typedef struct packed {
    logic [9:0] dx;
    logic [9:0] dy;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       hs_out;
    logic       vs_out;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] dx [N];
  logic [9:0] dy [N];
  logic       blank [N];
  logic       hs [N];
  logic       vs [N];
  logic       hs_out [N];
  logic       vs_out [N];
  logic       ls [N];
  logic       fs [N];
  logic [7:0] fc [N];

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q [N][$];

  always #5 vga_clk = ~vga_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_timing_gen #(
      .H_VISIBLE(HV[g]), .H_FP(HF[g]), .H_SYNC(HSY[g]), .H_BP(HB[g]),
      .V_VISIBLE(VV[g]), .V_FP(VF[g]), .V_SYNC(VSY[g]), .V_BP(VB[g]),
      .HS_POL(HP[g]), .VS_POL(VP[g]), .PIPE_DLY(PD[g])
    ) u_dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .DrawX      (dx[g]),
      .DrawY      (dy[g]),
      .blank      (blank[g]),
      .hs         (hs[g]),
      .vs         (vs[g]),
      .hs_out     (hs_out[g]),
      .vs_out     (vs_out[g]),
      .line_start (ls[g]),
      .frame_start(fs[g]),
      .frame_count(fc[g])
    );
  end

  // Sync level of instance i, t cycles after the first post-reset edge.
  function automatic logic sync_h(int i, int t);
    int ht = int'(HV[i] + HF[i] + HSY[i] + HB[i]);
    int x  = t % ht;
    if (t < 0) return ~HP[i];
    return (x >= int'(HV[i] + HF[i]) && x < int'(HV[i] + HF[i] + HSY[i])) ? HP[i] : ~HP[i];
  endfunction

  function automatic logic sync_v(int i, int t);
    int ht = int'(HV[i] + HF[i] + HSY[i] + HB[i]);
    int vt = int'(VV[i] + VF[i] + VSY[i] + VB[i]);
    int y  = (t / ht) % vt;
    if (t < 0) return ~VP[i];
    return (y >= int'(VV[i] + VF[i]) && y < int'(VV[i] + VF[i] + VSY[i])) ? VP[i] : ~VP[i];
  endfunction

  // t < 0 means "in reset"; t = 0 is the state after the first edge out of reset.
  function automatic obs_t model(int i, int t);
    obs_t e;
    int ht = int'(HV[i] + HF[i] + HSY[i] + HB[i]);
    int vt = int'(VV[i] + VF[i] + VSY[i] + VB[i]);
    int x, y;
    if (t < 0) begin
      e.dx = 10'(ht - 1);
      e.dy = 10'(vt - 1);
      e.blank = 1'b0;
      e.ls = 1'b0;
      e.fs = 1'b0;
      e.fc = 8'hFF;
    end else begin
      x = t % ht;
      y = (t / ht) % vt;
      e.dx = 10'(x);
      e.dy = 10'(y);
      e.blank = (x < int'(HV[i])) && (y < int'(VV[i]));
      e.ls = (x == 0);
      e.fs = (x == 0) && (y == 0);
      e.fc = 8'((t / (ht * vt)) % 256);
    end
    e.hs     = sync_h(i, t);
    e.vs     = sync_v(i, t);
    e.hs_out = sync_h(i, t - int'(PD[i]));
    e.vs_out = sync_v(i, t - int'(PD[i]));
    return e;
  endfunction

  function automatic obs_t sample(int i);
    obs_t o;
    o.dx = dx[i];
    o.dy = dy[i];
    o.blank = blank[i];
    o.hs = hs[i];
    o.vs = vs[i];
    o.hs_out = hs_out[i];
    o.vs_out = vs_out[i];
    o.ls = ls[i];
    o.fs = fs[i];
    o.fc = fc[i];
    return o;
  endfunction

  task automatic check(input string name, input int i, input logic [9:0] act,
                       input logic [9:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", name, i, $time, act, req);
    end
  endtask

  task automatic cmp_obs(input int i, input string tag, input obs_t a, input obs_t e);
    check({tag, ".DrawX"}, i, a.dx, e.dx);
    check({tag, ".DrawY"}, i, a.dy, e.dy);
    check({tag, ".blank"}, i, 10'(a.blank), 10'(e.blank));
    check({tag, ".hs"}, i, 10'(a.hs), 10'(e.hs));
    check({tag, ".vs"}, i, 10'(a.vs), 10'(e.vs));
    check({tag, ".hs_out"}, i, 10'(a.hs_out), 10'(e.hs_out));
    check({tag, ".vs_out"}, i, 10'(a.vs_out), 10'(e.vs_out));
    check({tag, ".line_start"}, i, 10'(a.ls), 10'(e.ls));
    check({tag, ".frame_start"}, i, 10'(a.fs), 10'(e.fs));
    check({tag, ".frame_count"}, i, 10'(a.fc), 10'(e.fc));
  endtask

  // Reference process: one expectation per instance per cycle; a reset flushes
  // anything pending because the frame is abandoned at once.
  initial begin
    int t_cnt = -1;
    forever begin
      @(posedge vga_clk or negedge reset_n);
      if (!reset_n) t_cnt = -1;
      else t_cnt++;
      for (int i = 0; i < N; i++) begin
        if (!reset_n) exp_q[i].delete();
        exp_q[i].push_back(model(i, t_cnt));
      end
    end
  end

  // Monitor: every cycle the DUT presents a new raster position; compare on the far edge.
  initial begin
    forever begin
      @(negedge vga_clk);
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0) cmp_obs(i, "sb", sample(i), exp_q[i].pop_front());
      end
    end
  end

  // Assert reset mid-cycle and require reset values before the next edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) cmp_obs(i, tag, sample(i), model(i, -1));
    repeat ($urandom_range(1, 6)) @(posedge vga_clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    repeat (5) @(posedge vga_clk);
    #2;
    for (int i = 0; i < N; i++) cmp_obs(i, "por", sample(i), model(i, -1));
    reset_n = 1'b1;

    // Run a few default lines, then reset asynchronously at DrawX=300 of line 3.
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(posedge vga_clk);
      #2;
      if (dx[1] == 10'd300 && dy[1] == 10'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_x300 got=timeout want=DrawX300_DrawY3");
    end
    async_reset("mid_rst");

    // Random run lengths followed by random mid-cycle resets.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(200, 3000)) @(posedge vga_clk);
      #($urandom_range(1, 4));
      async_reset("rnd_rst");
    end

    // Long run: tiny raster passes 256 frames so frame_count wraps.
    repeat (13000) @(posedge vga_clk);
    @(negedge vga_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
